// File: rtl/log_prod_tree_pkg.sv
// Shared encodings and arithmetic for the log-domain product tree.
// Values are handled at 64 bits and narrowed by the caller to its own width.
package log_prod_tree_pkg;

    typedef struct packed {
        logic signed [63:0] sum;
        logic               sat;
    } sat_res_t;

    function automatic logic signed [63:0] max_val(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] min_fin(input int unsigned w);
        return -max_val(w);
    endfunction

    function automatic logic signed [63:0] neg_inf(input int unsigned w);
        return -max_val(w) - 64'sd1;
    endfunction

    // log(a*b) = log a + log b; log 0 absorbs, finite results clamp to [MIN_FIN, MAX]
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int unsigned        w);
        sat_res_t r;
        r.sum = a + b;
        r.sat = 1'b0;
        if (a == neg_inf(w) || b == neg_inf(w)) begin
            r.sum = neg_inf(w);
        end else if (r.sum > max_val(w)) begin
            r.sum = max_val(w);
            r.sat = 1'b1;
        end else if (r.sum < min_fin(w)) begin
            r.sum = min_fin(w);
            r.sat = 1'b1;
        end
        return r;
    endfunction

    function automatic int unsigned clamp_mode(input int unsigned m, input int unsigned levels);
        return (m > levels) ? levels : m;
    endfunction

    // One spare code point so an over-range mode can be presented and clamped.
    function automatic int unsigned mode_width(input int unsigned n_leaf);
        return $clog2($clog2(n_leaf) + 2);
    endfunction

endpackage

// File: rtl/log_prod_tree_if.sv
// Input and output streaming handshake of the log-domain product tree.
interface log_prod_tree_if #(
    parameter int N_LEAF = 8,
    parameter int W      = 16
);
    import log_prod_tree_pkg::*;

    localparam int MODE_W = mode_width(N_LEAF);

    logic                  in_valid;
    logic                  in_ready;
    logic [N_LEAF*W-1:0]   in_data;
    logic [MODE_W-1:0]     mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_LEAF*W-1:0]   out_data;
    logic [N_LEAF-1:0]     out_mask;
    logic [MODE_W-1:0]     out_mode;
    logic                  out_sat;

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data, out_mask, out_mode, out_sat
    );

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data, out_mask, out_mode, out_sat
    );
endinterface

// File: rtl/log_prod_tree_add_stage.sv
// One tree level: pairs adjacent lanes with a saturating log-domain add when the
// transaction's mode reaches this level, otherwise passes lanes through.
module log_add_stage
    import log_prod_tree_pkg::*;
#(
    parameter int N_LEAF = 8,
    parameter int W      = 16,
    parameter int LEVEL  = 1,
    parameter int MODE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic                valid_i,
    input  logic [N_LEAF*W-1:0] data_i,
    input  logic [MODE_W-1:0]   mode_i,
    input  logic                sat_i,
    output logic                valid_o,
    output logic [N_LEAF*W-1:0] data_o,
    output logic [MODE_W-1:0]   mode_o,
    output logic                sat_o
);

    logic                valid_q;
    logic [N_LEAF*W-1:0] data_q, data_d;
    logic [MODE_W-1:0]   mode_q;
    logic                sat_q, sat_d;
    logic                unused_sum_hi;

    always_comb begin
        sat_res_t res;
        res           = '0;
        data_d        = data_i;
        sat_d         = sat_i;
        unused_sum_hi = 1'b0;
        if (mode_i >= MODE_W'(LEVEL)) begin
            data_d = '0;
            for (int j = 0; j < (N_LEAF >> LEVEL); j++) begin
                res = sat_add(64'($signed(data_i[2*j*W +: W])),
                              64'($signed(data_i[(2*j+1)*W +: W])), W);
                data_d[j*W +: W] = res.sum[W-1:0];
                sat_d            = sat_d | res.sat;
                // result is already in range, so the upper bits are pure sign extension
                unused_sum_hi    = unused_sum_hi | (|res.sum[63:W]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= '0;
            sat_q   <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_d;
                mode_q <= mode_i;
                sat_q  <= sat_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign mode_o  = mode_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/log_prod_tree.sv
// Pipelined log-domain product tree: LEVELS lock-step stages sharing one enable,
// fixed latency of LEVELS cycles whatever the group size.
module log_prod_tree
    import log_prod_tree_pkg::*;
#(
    parameter int N_LEAF = 8,
    parameter int W      = 16,
    parameter int FRAC   = 10
) (
    input  logic            clk,
    input  logic            rst,
    log_prod_tree_if.slave  bus
);

    localparam int LEVELS = $clog2(N_LEAF);
    localparam int MODE_W = mode_width(N_LEAF);

    if (N_LEAF < 2 || (N_LEAF & (N_LEAF - 1)) != 0 || FRAC >= W) begin : g_param_err
        $error("log_prod_tree: N_LEAF must be a power of 2 >= 2 and FRAC < W");
    end

    logic                en;
    logic [N_LEAF*W-1:0] data_s  [LEVELS+1];
    logic [MODE_W-1:0]   mode_s  [LEVELS+1];
    logic                valid_s [LEVELS+1];
    logic                sat_s   [LEVELS+1];
    logic [N_LEAF-1:0]   mask;

    assign en          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = rst & en;

    assign data_s[0]  = bus.in_data;
    assign mode_s[0]  = MODE_W'(clamp_mode(32'(bus.mode), LEVELS));
    assign valid_s[0] = bus.in_valid;
    assign sat_s[0]   = 1'b0;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
        log_add_stage #(
            .N_LEAF (N_LEAF),
            .W      (W),
            .LEVEL  (k),
            .MODE_W (MODE_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (en),
            .valid_i (valid_s[k-1]),
            .data_i  (data_s[k-1]),
            .mode_i  (mode_s[k-1]),
            .sat_i   (sat_s[k-1]),
            .valid_o (valid_s[k]),
            .data_o  (data_s[k]),
            .mode_o  (mode_s[k]),
            .sat_o   (sat_s[k])
        );
    end

    always_comb begin
        mask = '0;
        for (int g = 0; g < N_LEAF; g++) begin
            if (valid_s[LEVELS] && g < (N_LEAF >> mode_s[LEVELS])) begin
                mask[g] = 1'b1;
            end
        end
    end

    assign bus.out_valid = valid_s[LEVELS];
    assign bus.out_data  = data_s[LEVELS];
    assign bus.out_mode  = mode_s[LEVELS];
    assign bus.out_sat   = sat_s[LEVELS];
    assign bus.out_mask  = mask;

endmodule

// File: tb/tb_log_prod_tree.sv
// Directed bench for log_prod_tree: expected results queued at accept time from a
// behavioural model, popped and compared when the DUT hands a result downstream.
module tb_log_prod_tree;

    localparam int NL = 8;
    localparam int W  = 16;

    typedef struct {
        logic [127:0] data;
        logic [7:0]   mask;
        logic [2:0]   mode;
        logic         sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    log_prod_tree_if #(.N_LEAF(NL), .W(W)) bus ();

    log_prod_tree #(.N_LEAF(NL), .W(W), .FRAC(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t         sb[$];
    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [127:0] last_data;
    logic [7:0]   last_mask;
    logic [2:0]   last_mode;
    logic         last_sat;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [127:0] d, input int m);
        exp_t e;
        int   v[8];
        int   a, b, s, mc;
        mc    = (m > 3) ? 3 : m;
        e.sat = 1'b0;
        for (int i = 0; i < 8; i++) v[i] = int'($signed(d[i*16 +: 16]));
        for (int k = 1; k <= mc; k++) begin
            for (int j = 0; j < (8 >> k); j++) begin
                a = v[2*j];
                b = v[2*j+1];
                if (a == -32768 || b == -32768) begin
                    s = -32768;
                end else begin
                    s = a + b;
                    if (s > 32767) begin
                        s = 32767;  e.sat = 1'b1;
                    end else if (s < -32767) begin
                        s = -32767; e.sat = 1'b1;
                    end
                end
                v[j] = s;
            end
        end
        e.data = '0;
        for (int j = 0; j < (8 >> mc); j++) e.data[j*16 +: 16] = 16'(v[j]);
        e.mask = 8'((1 << (8 >> mc)) - 1);
        e.mode = 3'(mc);
        return e;
    endfunction

    task automatic send(input logic [127:0] d, input int unsigned m);
        int tries;
        tries = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.mode     = 3'(m);
        #1;
        while (bus.in_ready !== 1'b1 && tries < 50) begin
            @(negedge clk);
            #1;
            tries++;
        end
        chk("accept_in_time", 128'(tries < 50), 128'(1));
        sb.push_back(model(d, int'(m)));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            #3;
            t++;
        end
        chk(tag, 128'(sb.size()), 128'(0));
    endtask

    initial begin
        logic [127:0] d;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.mode      = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    #2;
                    if (rst && bus.out_valid && bus.out_ready) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_output", 128'(bus.out_valid), 128'(0));
                        end else begin
                            e = sb.pop_front();
                            chk("out_data", bus.out_data, e.data);
                            chk("out_mask", 128'(bus.out_mask), 128'(e.mask));
                            chk("out_mode", 128'(bus.out_mode), 128'(e.mode));
                            chk("out_sat",  128'(bus.out_sat),  128'(e.sat));
                            last_data = bus.out_data;
                            last_mask = bus.out_mask;
                            last_mode = bus.out_mode;
                            last_sat  = bus.out_sat;
                        end
                    end
                end
            end
            begin : watchdog
                #200000;
                $display("FAIL watchdog: simulation time exceeded, observed no completion, required finish");
                $fatal(1, "watchdog");
            end
        join_none

        #12;
        chk("rst_in_ready",  128'(bus.in_ready),  128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_data",  bus.out_data,        128'(0));
        chk("rst_out_mask",  128'(bus.out_mask),  128'(0));
        chk("rst_out_mode",  128'(bus.out_mode),  128'(0));
        chk("rst_out_sat",   128'(bus.out_sat),   128'(0));
        @(negedge clk);
        rst = 1'b1;

        // full tree of -1.0 leaves, with exact latency check
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'hFC00;
        send(d, 3);
        @(posedge clk); #1;
        chk("lat_cycle2_not_valid", 128'(bus.out_valid), 128'(0));
        @(posedge clk); #1;
        chk("lat_cycle3_valid", 128'(bus.out_valid), 128'(1));
        drain("drain_t1");
        chk("t1_slot0", 128'(last_data[15:0]), 128'(16'hE000));
        chk("t1_slots_hi", 128'(last_data[127:16]), 128'(0));
        chk("t1_mask", 128'(last_mask), 128'(8'h01));
        chk("t1_sat", 128'(last_sat), 128'(0));

        // pairwise products, then identity
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'(i * 16'h0400);
        send(d, 1);
        drain("drain_t2a");
        chk("t2_slots", last_data, {64'h0, 64'h3400_2400_1400_0400});
        chk("t2_mask", 128'(last_mask), 128'(8'h0F));
        chk("t2_mode", 128'(last_mode), 128'(1));
        send(d, 0);
        drain("drain_t2b");
        chk("t2_identity", last_data, d);
        chk("t2_mask0", 128'(last_mask), 128'(8'hFF));

        // log 0 absorbs; first case still overflows in the finite pairs
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'h7000;
        d[3*16 +: 16] = 16'h8000;
        send(d, 3);
        drain("drain_t3a");
        chk("t3_slot0_neginf", 128'(last_data[15:0]), 128'(16'h8000));
        chk("t3_sat_finite_pairs", 128'(last_sat), 128'(1));
        d = '0;
        d[2*16 +: 16] = 16'h7FFF;
        d[3*16 +: 16] = 16'h8000;
        send(d, 3);
        drain("drain_t3b");
        chk("t3b_slot0_neginf", 128'(last_data[15:0]), 128'(16'h8000));
        chk("t3b_no_sat", 128'(last_sat), 128'(0));

        // saturation at both ends, then a clean transaction clears the flag
        d = '0;
        d[0*16 +: 16] = 16'hC000;
        d[1*16 +: 16] = 16'hC000;
        d[2*16 +: 16] = 16'h7000;
        d[3*16 +: 16] = 16'h7000;
        send(d, 1);
        drain("drain_t4a");
        chk("t4_slot0_minfin", 128'(last_data[15:0]), 128'(16'h8001));
        chk("t4_slot1_max", 128'(last_data[31:16]), 128'(16'h7FFF));
        chk("t4_sat", 128'(last_sat), 128'(1));
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'h0100;
        send(d, 2);
        drain("drain_t4b");
        chk("t4b_slots", last_data, {96'h0, 32'h0400_0400});
        chk("t4b_sat_clear", 128'(last_sat), 128'(0));

        // back-to-back stream with a 3-cycle downstream stall
        fork
            begin : stream
                logic [127:0] r;
                for (int n = 0; n < 6; n++) begin
                    r = {$urandom, $urandom, $urandom, $urandom};
                    send(r, n % 4);
                end
            end
            begin : stall
                int           t;
                logic [127:0] held;
                t = 0;
                @(negedge clk);
                while (bus.out_valid !== 1'b1 && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                chk("stall_first_valid", 128'(bus.out_valid), 128'(1));
                bus.out_ready = 1'b0;
                held = bus.out_data;
                for (int c = 0; c < 3; c++) begin
                    #1;
                    chk("stall_in_ready_low", 128'(bus.in_ready), 128'(0));
                    chk("stall_data_stable", bus.out_data, held);
                    chk("stall_valid_held", 128'(bus.out_valid), 128'(1));
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain("drain_stream");

        // reset with two transactions in flight
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'h0200;
        send(d, 2);
        send(d, 3);
        @(posedge clk);
        #2;
        chk("pre_reset_valid", 128'(bus.out_valid), 128'(1));
        rst = 1'b0;
        #1;
        chk("async_rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("async_rst_out_data", bus.out_data, 128'(0));
        chk("async_rst_in_ready", 128'(bus.in_ready), 128'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("no_stale_output", 128'(bus.out_valid), 128'(0));
        end
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'(i * 16'h0100);
        send(d, 5);
        drain("drain_t6");
        chk("t6_mode_clamped", 128'(last_mode), 128'(3));
        chk("t6_slot0", 128'(last_data[15:0]), 128'(16'h1C00));
        chk("t6_mask", 128'(last_mask), 128'(8'h01));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
